sig_echo_delay: RTL and testbench
=================================

Name: sig_echo_delay

Overview:
Parametrised circular-buffer delay line for the sine/voice path. Each input sample strobe writes one sample into an internal dual-port RAM and reads back the sample from a runtime-programmable number of strobes earlier. Mode 0 is a pure delay. Mode 1 is a feedback echo: the mixed output is written back into the buffer. The block sits between the waveform generator and the output sink, and replaces the fixed counter+RAM delay pairing.

Parameters:
A_WIDTH, 9, address width; buffer depth = 2**A_WIDTH samples; max delay = 2**A_WIDTH-1
D_WIDTH, 8, sample width; offset-binary unsigned, silence = 2**(D_WIDTH-1)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
en  input  1  sample strobe; one sample accepted per high cycle; back-to-back allowed
mode  input  1  0 = delay, 1 = echo (feedback); sampled on en
delay  input  A_WIDTH  delay in strobes; sampled on en
din  input  D_WIDTH  input sample; sampled on en
dout  output  D_WIDTH  output sample
dout_valid  output  1  one-cycle pulse per accepted strobe
primed  output  1  1 when the last output came from real history

Behaviour:
- Reset state: dout=2**(D_WIDTH-1), dout_valid=0, primed=0. Write pointer, fill counter and pipeline valids are cleared. RAM contents are NOT cleared.
- Stage 0 (edge ending the en cycle t):
  - Latch din, mode, d=delay, waddr=wptr, raddr=(wptr-d) mod 2**A_WIDTH.
  - Issue the synchronous RAM read.
  - wptr += 1 (wraps).
  - hist = (fill_cnt >= d); fill_cnt += 1, saturating at 2**A_WIDTH-1.
- Stage 1 (edge ending cycle t+1):
  - Compute delayed:
    - d==0: delayed = din of the same strobe (bypass, no RAM use).
    - hist==0: delayed = midscale.
    - Otherwise delayed = RAM read data.
  - Forwarding: if the stage-0 read address equals the stage-1 write address in the same cycle (d==1 with back-to-back en), delayed takes the value being written.
  - Mode 0: wdata=din, dout=delayed.
  - Mode 1: mix=(din+delayed)>>1, computed in D_WIDTH+1 bits and truncated; wdata=mix, dout=mix.
  - Write mem[waddr]=wdata. Assert dout_valid for one cycle. primed=hist (or 1 if d==0).
- Latency: dout/dout_valid are visible in cycle t+2 for en in cycle t. Throughput is 1 sample/cycle.
- dout holds its value between pulses.
- Delay changes take effect on the next strobe. If the new delay exceeds fill_cnt, primed drops and outputs return to midscale until the buffer has filled to the new delay.
- Wrap-around: the pointer wraps modulo depth with no gap. Max delay 2**A_WIDTH-1 is legal; delay is never clamped.
- Reset concurrent with en or with a strobe in flight: reset wins, the in-flight strobe is discarded (no dout_valid pulse, no write), and outputs go to reset values.

Decomposition:
- Package sig_delay_pkg:
  - mode constants MODE_DELAY=1'b0, MODE_ECHO=1'b1
  - function midscale(D_WIDTH)
- One sub-module, delay_ram: simple dual-port RAM with 1 write port, 1 synchronous read port and no read-during-write guarantee. Forwarding lives in sig_echo_delay.

Test Plan:
(All cases use A_WIDTH=4, D_WIDTH=8.)
1. Assert rst -> dout=128, dout_valid=0, primed=0. Release rst with en low -> no dout_valid pulses.
2. Mode 0, delay=3, din=10,20,30,40,50 on consecutive cycles -> dout=128,128,128,10,20, each 2 cycles after its en. primed=0,0,0,1,1.
3. Mode 0, delay=1, back-to-back din=5,6,7,8 -> dout=128,5,6,7; checks the forwarding path.
4. Mode 0, delay=15, 20 strobes din=k -> strobes 0..14 give 128; strobe 15 gives 0, strobe 16 gives 1, ..., strobe 19 gives 4; checks wrap.
5. Mode 1, delay=2, din=200 constant -> dout=164,164,182,182,191,191.
6. Delay=0 -> dout=din and primed=1 immediately. Then assert rst during an in-flight strobe -> no pulse for that strobe, primed=0; after release with delay=2, the first two outputs are 128.

Source files
------------

// File: rtl/sig_delay_pkg.sv
// Shared constants and helpers for the sine/voice path delay line.
package sig_delay_pkg;

    localparam logic MODE_DELAY = 1'b0;
    localparam logic MODE_ECHO  = 1'b1;

    // Offset-binary silence level for a sample of the given width.
    function automatic int unsigned midscale(input int unsigned dw);
        return 32'd1 << (dw - 32'd1);
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-during-write to the same address returns undefined data; callers forward.
module delay_ram #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [A_WIDTH-1:0] waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               re,
    input  logic [A_WIDTH-1:0] raddr,
    output logic [D_WIDTH-1:0] rdata
);

    logic [D_WIDTH-1:0] mem [2**A_WIDTH];
    logic [D_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sig_echo_delay.sv
// Circular-buffer delay line with optional feedback echo.
// en is a one-cycle strobe with no back-pressure: every high cycle accepts a sample.
module sig_echo_delay
    import sig_delay_pkg::*;
#(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [A_WIDTH-1:0] delay,
    input  logic [D_WIDTH-1:0] din,
    output logic [D_WIDTH-1:0] dout,
    output logic               dout_valid,
    output logic               primed
);

    localparam logic [D_WIDTH-1:0] MID      = D_WIDTH'(midscale(D_WIDTH));
    localparam logic [A_WIDTH-1:0] FILL_MAX = '1;

    logic [A_WIDTH-1:0] wptr_q, wptr_d;
    logic [A_WIDTH-1:0] fill_q, fill_d;

    logic               s0_valid_q, s0_valid_d;
    logic               s0_mode_q, s0_mode_d;
    logic [D_WIDTH-1:0] s0_din_q, s0_din_d;
    logic               s0_dzero_q, s0_dzero_d;
    logic               s0_hist_q, s0_hist_d;
    logic [A_WIDTH-1:0] s0_waddr_q, s0_waddr_d;
    logic               s0_fwd_q, s0_fwd_d;
    logic [D_WIDTH-1:0] s0_fwd_data_q, s0_fwd_data_d;

    logic [D_WIDTH-1:0] dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               primed_q, primed_d;

    logic [A_WIDTH-1:0] raddr;
    logic [D_WIDTH-1:0] ram_rdata;
    logic [D_WIDTH-1:0] delayed;
    logic [D_WIDTH:0]   mix_wide;
    logic [D_WIDTH-1:0] mix;
    logic [D_WIDTH-1:0] wdata;
    logic [D_WIDTH-1:0] out_val;
    logic               ram_we;

    // Stage 0: capture the strobe and launch the RAM read.
    always_comb begin
        raddr         = wptr_q - delay;
        wptr_d        = wptr_q;
        fill_d        = fill_q;
        s0_valid_d    = en;
        s0_mode_d     = s0_mode_q;
        s0_din_d      = s0_din_q;
        s0_dzero_d    = s0_dzero_q;
        s0_hist_d     = s0_hist_q;
        s0_waddr_d    = s0_waddr_q;
        s0_fwd_d      = 1'b0;
        s0_fwd_data_d = s0_fwd_data_q;
        if (en) begin
            wptr_d        = wptr_q + 1'b1;
            fill_d        = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
            s0_mode_d     = mode;
            s0_din_d      = din;
            s0_dzero_d    = (delay == '0);
            s0_hist_d     = (fill_q >= delay);
            s0_waddr_d    = wptr_q;
            // The RAM cannot return the word being written this cycle, so keep it aside.
            s0_fwd_d      = s0_valid_q && (raddr == s0_waddr_q);
            s0_fwd_data_d = wdata;
        end
    end

    // Stage 1: pick the delayed sample, mix, write back and present the output.
    always_comb begin
        if (s0_dzero_q) begin
            delayed = s0_din_q;
        end else if (!s0_hist_q) begin
            delayed = MID;
        end else if (s0_fwd_q) begin
            delayed = s0_fwd_data_q;
        end else begin
            delayed = ram_rdata;
        end
        mix_wide = {1'b0, s0_din_q} + {1'b0, delayed};
        mix      = mix_wide[D_WIDTH:1];
        wdata    = (s0_mode_q == MODE_ECHO) ? mix : s0_din_q;
        out_val  = (s0_mode_q == MODE_ECHO) ? mix : delayed;
        ram_we   = s0_valid_q && !rst;

        dout_valid_d = s0_valid_q;
        dout_d       = s0_valid_q ? out_val : dout_q;
        primed_d     = s0_valid_q ? (s0_hist_q || s0_dzero_q) : primed_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q        <= '0;
            fill_q        <= '0;
            s0_valid_q    <= 1'b0;
            s0_mode_q     <= MODE_DELAY;
            s0_din_q      <= '0;
            s0_dzero_q    <= 1'b0;
            s0_hist_q     <= 1'b0;
            s0_waddr_q    <= '0;
            s0_fwd_q      <= 1'b0;
            s0_fwd_data_q <= '0;
            dout_q        <= MID;
            dout_valid_q  <= 1'b0;
            primed_q      <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            fill_q        <= fill_d;
            s0_valid_q    <= s0_valid_d;
            s0_mode_q     <= s0_mode_d;
            s0_din_q      <= s0_din_d;
            s0_dzero_q    <= s0_dzero_d;
            s0_hist_q     <= s0_hist_d;
            s0_waddr_q    <= s0_waddr_d;
            s0_fwd_q      <= s0_fwd_d;
            s0_fwd_data_q <= s0_fwd_data_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            primed_q      <= primed_d;
        end
    end

    delay_ram #(
        .A_WIDTH(A_WIDTH),
        .D_WIDTH(D_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (s0_waddr_q),
        .wdata (wdata),
        .re    (en),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign primed     = primed_q;

endmodule

// File: tb/tb_sig_echo_delay.sv
// Directed bench for sig_echo_delay with A_WIDTH=4, D_WIDTH=8.
module tb_sig_echo_delay;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [3:0] delay;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       primed;

    int checks = 0;
    int errors = 0;

    // {primed, dout} expected for each accepted strobe, in order.
    logic [8:0] exp_q[$];
    logic       pend = 1'b0;
    logic [7:0] last_dout = 8'd128;
    logic       last_primed = 1'b0;

    sig_echo_delay #(
        .A_WIDTH(4),
        .D_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .delay      (delay),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .primed     (primed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    // One clock; then checks outputs against the strobe captured on the previous edge.
    task automatic tick();
        logic       cur;
        logic       rs;
        logic [8:0] e;
        cur = en;
        rs  = rst;
        @(posedge clk);
        #1;
        if (rs) begin
            exp_q.delete();
            pend        = 1'b0;
            last_dout   = 8'd128;
            last_primed = 1'b0;
            chk8("rst_dout", dout, 8'd128);
            chk1("rst_valid", dout_valid, 1'b0);
            chk1("rst_primed", primed, 1'b0);
        end else begin
            chk1("valid", dout_valid, pend);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    chk1("exp_underflow", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk8("dout", dout, e[7:0]);
                    chk1("primed", primed, e[8]);
                    last_dout   = e[7:0];
                    last_primed = e[8];
                end
            end else begin
                chk8("dout_hold", dout, last_dout);
                chk1("primed_hold", primed, last_primed);
            end
            pend = cur;
        end
    endtask

    task automatic strobe(input logic m, input logic [3:0] d, input logic [7:0] x,
                          input logic [7:0] ed, input logic ep);
        en    = 1'b1;
        mode  = m;
        delay = d;
        din   = x;
        exp_q.push_back({ep, ed});
        tick();
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        en  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        delay = 4'd0;
        din   = 8'd0;

        // 1: reset, then quiet with en low
        do_reset();
        idle(3);

        // 2: pure delay of 3
        strobe(1'b0, 4'd3, 8'd10, 8'd128, 1'b0);
        strobe(1'b0, 4'd3, 8'd20, 8'd128, 1'b0);
        strobe(1'b0, 4'd3, 8'd30, 8'd128, 1'b0);
        strobe(1'b0, 4'd3, 8'd40, 8'd10,  1'b1);
        strobe(1'b0, 4'd3, 8'd50, 8'd20,  1'b1);
        idle(3);

        // 3: delay 1 back-to-back exercises forwarding
        do_reset();
        strobe(1'b0, 4'd1, 8'd5, 8'd128, 1'b0);
        strobe(1'b0, 4'd1, 8'd6, 8'd5,   1'b1);
        strobe(1'b0, 4'd1, 8'd7, 8'd6,   1'b1);
        strobe(1'b0, 4'd1, 8'd8, 8'd7,   1'b1);
        idle(3);

        // 4: maximum delay and pointer wrap
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k < 15) strobe(1'b0, 4'd15, 8'(k), 8'd128, 1'b0);
            else        strobe(1'b0, 4'd15, 8'(k), 8'(k - 15), 1'b1);
        end
        idle(3);

        // 5: feedback echo, delay 2, constant 200
        do_reset();
        strobe(1'b1, 4'd2, 8'd200, 8'd164, 1'b0);
        strobe(1'b1, 4'd2, 8'd200, 8'd164, 1'b0);
        strobe(1'b1, 4'd2, 8'd200, 8'd182, 1'b1);
        strobe(1'b1, 4'd2, 8'd200, 8'd182, 1'b1);
        strobe(1'b1, 4'd2, 8'd200, 8'd191, 1'b1);
        strobe(1'b1, 4'd2, 8'd200, 8'd191, 1'b1);
        idle(3);

        // 6: delay 0 bypass, then reset with a strobe in flight
        do_reset();
        strobe(1'b0, 4'd0, 8'd33, 8'd33, 1'b1);
        strobe(1'b0, 4'd0, 8'd77, 8'd77, 1'b1);
        idle(3);
        strobe(1'b0, 4'd0, 8'd99, 8'd99, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);
        strobe(1'b0, 4'd2, 8'd1, 8'd128, 1'b0);
        strobe(1'b0, 4'd2, 8'd2, 8'd128, 1'b0);
        strobe(1'b0, 4'd2, 8'd3, 8'd1,   1'b1);
        idle(3);

        // Reset concurrent with en: the strobe is dropped
        en    = 1'b1;
        din   = 8'd55;
        delay = 4'd0;
        rst   = 1'b1;
        tick();
        en  = 1'b0;
        tick();
        rst = 1'b0;
        idle(3);

        chk8("exp_q_empty", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
